// File: rtl/hcsr04_ranger_if.sv
// Sensor-pin and controller-side signals of the HC-SR04 ranger.
// master: the ranger itself; slave: the controller/pin side that drives enable and echo.
interface hcsr04_ranger_if #(
    parameter int unsigned DIST_W = 16
);
    logic              enable_i;
    logic              echo_i;
    logic              trigger_o;
    logic [DIST_W-1:0] dist_mm_o;
    logic              valid_o;
    logic              timeout_o;
    logic              busy_o;

    modport master (
        input  enable_i,
        input  echo_i,
        output trigger_o,
        output dist_mm_o,
        output valid_o,
        output timeout_o,
        output busy_o
    );

    modport slave (
        output enable_i,
        output echo_i,
        input  trigger_o,
        input  dist_mm_o,
        input  valid_o,
        input  timeout_o,
        input  busy_o
    );
endinterface

// File: rtl/hcsr04_ranger.sv
// HC-SR04 driver: periodic trigger pulse, echo width measured in mm via a
// cycles-per-mm sub-counter, reported with a one-cycle valid or timeout strobe.
module hcsr04_ranger #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned PERIOD_CYCLES  = 3000000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned CYCLES_PER_MM  = 291,
    parameter int unsigned MAX_MM         = 4000,
    parameter int unsigned DIST_W         = 16
) (
    input logic             clk,
    input logic             rst_n,
    hcsr04_ranger_if.master bus
);
    localparam int unsigned PerW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned SubW = (CYCLES_PER_MM > 1) ? $clog2(CYCLES_PER_MM) : 1;
    localparam int unsigned MmW  = $clog2(MAX_MM + 1);

    localparam logic [PerW-1:0] PerLast  = PerW'(PERIOD_CYCLES - 1);
    localparam logic [PerW-1:0] TrigLast = PerW'(TRIG_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [SubW-1:0] SubLast  = SubW'(CYCLES_PER_MM - 1);
    localparam logic [MmW-1:0]  MmMax    = MmW'(MAX_MM);

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StHoldoff
    } state_e;

    state_e            state_q, state_d;
    logic [PerW-1:0]   period_q, period_d;
    logic [TmoW-1:0]   timer_q, timer_d;
    logic [SubW-1:0]   sub_q, sub_d, sub_next;
    logic [MmW-1:0]    mm_q, mm_d, mm_next;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic              echo_meta_q, echo_sync_q, echo_prev_q;
    logic              echo_rise, echo_fall;

    // Two-flop synchronizer plus a registered copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            echo_meta_q <= bus.echo_i;
            echo_sync_q <= echo_meta_q;
            echo_prev_q <= echo_sync_q;
        end
    end

    assign echo_rise = echo_sync_q & ~echo_prev_q;
    assign echo_fall = ~echo_sync_q & echo_prev_q;
    assign sub_next  = (sub_q == SubLast) ? '0 : sub_q + 1'b1;
    assign mm_next   = (sub_q == SubLast) ? mm_q + 1'b1 : mm_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        sub_d     = sub_q;
        mm_d      = mm_q;
        dist_d    = dist_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        // Period counter saturates so a long measurement just shortens HOLDOFF.
        period_d  = (period_q == PerLast) ? period_q : period_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                period_d = '0;
                timer_d  = '0;
                sub_d    = '0;
                mm_d     = '0;
                if (bus.enable_i) state_d = StTrig;
            end
            StTrig: begin
                timer_d = '0;
                sub_d   = '0;
                mm_d    = '0;
                if (period_q == TrigLast) state_d = StWaitRise;
            end
            StWaitRise: begin
                timer_d = timer_q + 1'b1;
                // The rise cycle already has echo high, so it is counted too.
                if (echo_rise) begin
                    sub_d   = sub_next;
                    mm_d    = mm_next;
                    state_d = StMeasure;
                end else if (timer_q == TmoLast) begin
                    timeout_d = 1'b1;
                    state_d   = StHoldoff;
                end
            end
            StMeasure: begin
                if (echo_fall) begin
                    dist_d  = DIST_W'(mm_q);
                    valid_d = 1'b1;
                    state_d = StHoldoff;
                end else if (echo_sync_q) begin
                    sub_d = sub_next;
                    mm_d  = mm_next;
                    if (mm_next == MmMax) begin
                        timeout_d = 1'b1;
                        state_d   = StHoldoff;
                    end
                end
            end
            StHoldoff: begin
                if (period_q == PerLast) begin
                    period_d = '0;
                    state_d  = bus.enable_i ? StTrig : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            period_q  <= '0;
            timer_q   <= '0;
            sub_q     <= '0;
            mm_q      <= '0;
            dist_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            timer_q   <= timer_d;
            sub_q     <= sub_d;
            mm_q      <= mm_d;
            dist_q    <= dist_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Decoded from the state register so reset drops the trigger asynchronously.
    assign bus.trigger_o = (state_q == StTrig);
    assign bus.busy_o    = (state_q != StIdle);
    assign bus.dist_mm_o = dist_q;
    assign bus.valid_o   = valid_q;
    assign bus.timeout_o = timeout_q;
endmodule
